// File: rtl/pcm_mm_pkg.sv
// Shared types and defaults for the PCM memory-manager request registers.
// Build option: PCM_MM_REQ_TIMEOUT_EN enables the pending-request timeout.
package pcm_mm_pkg;

   localparam int PCM_ADDR_W = 20;
   localparam int PCM_DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      DONE    = 2'd2
   } req_state_t;

   // Replicated across the data width to form the timeout fill word.
   localparam logic TMO_FILL_BIT = 1'b1;

endpackage

// File: rtl/pcm_mm_req_reg.sv
// Per-CPU request register: holds one outstanding PCM request for the arbiter.
// Build option: PCM_MM_REQ_TIMEOUT_EN completes stuck requests with all-ones.
module pcm_mm_req_reg
   import pcm_mm_pkg::*;
#(
   parameter int ADDR_W         = PCM_ADDR_W,
   parameter int DATA_W         = PCM_DATA_W,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              init,
   input  logic [ADDR_W-1:0] addr,
   input  logic              cpu_write,
   input  logic [DATA_W-1:0] cpu_in,
   input  logic [DATA_W-1:0] data_in,
   input  logic              resolved,
   output logic              schedule,
   output logic              cpu_ready,
   output logic [DATA_W-1:0] cpu_out,
   output logic [ADDR_W-1:0] addr_reg
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   req_state_t        state_q, state_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] out_d;
   logic              rdy_d;
   logic              wr_prev;
   logic              is_wr_q, is_wr_d;
   logic              wr_rise;
   logic              rd_req;
   logic              new_req;

   assign wr_rise = cpu_write & ~wr_prev;
   assign rd_req  = (addr != addr_reg);
   assign new_req = (state_q != PENDING) & (wr_rise | rd_req);

   // Zero-latency request so the arbiter sees it on the detecting cycle.
   assign schedule = ~reset & ~init &
                     ((state_q == PENDING) | new_req);

`ifdef PCM_MM_REQ_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             expired;

   assign expired = (state_q == PENDING) & ~resolved &
                    (cnt_q == CNT_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
`else
   logic expired;
   assign expired = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_reg;
      out_d   = cpu_out;
      rdy_d   = cpu_ready;
      is_wr_d = is_wr_q;
`ifdef PCM_MM_REQ_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      if (init) begin
         addr_d  = addr;
         state_d = IDLE;
         rdy_d   = 1'b0;
      end else begin
         unique case (state_q)
            IDLE, DONE: begin
               if (new_req) begin
                  addr_d  = addr;
                  is_wr_d = wr_rise;
                  rdy_d   = 1'b0;
                  state_d = PENDING;
                  if (wr_rise) out_d = cpu_in;
`ifdef PCM_MM_REQ_TIMEOUT_EN
                  cnt_d = '0;
`endif
               end
            end
            PENDING: begin
               if (resolved) begin
                  if (!is_wr_q) out_d = data_in;
                  rdy_d   = 1'b1;
                  state_d = DONE;
               end else if (expired) begin
                  out_d   = {DATA_W{TMO_FILL_BIT}};
                  rdy_d   = 1'b1;
                  state_d = DONE;
               end
`ifdef PCM_MM_REQ_TIMEOUT_EN
               else begin
                  cnt_d = cnt_q + 1'b1;
               end
`endif
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         addr_reg  <= '0;
         cpu_out   <= '0;
         cpu_ready <= 1'b0;
         wr_prev   <= 1'b0;
         is_wr_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_reg  <= addr_d;
         cpu_out   <= out_d;
         cpu_ready <= rdy_d;
         wr_prev   <= cpu_write;
         is_wr_q   <= is_wr_d;
      end
   end

endmodule

// File: tb/tb_pcm_mm_req_reg.sv
// Self-checking bench for pcm_mm_req_reg: directed scenarios plus a
// randomized run against a transaction-level request model.
module tb_pcm_mm_req_reg;

   localparam int AW  = 20;
   localparam int DW  = 16;
   localparam int TMO = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          init = 1'b0;
   logic [AW-1:0] addr = '0;
   logic          cpu_write = 1'b0;
   logic [DW-1:0] cpu_in = '0;
   logic [DW-1:0] data_in = '0;
   logic          resolved = 1'b0;
   logic          schedule;
   logic          cpu_ready;
   logic [DW-1:0] cpu_out;
   logic [AW-1:0] addr_reg;

   int n_chk = 0;
   int n_fail = 0;

   // Reference model: one outstanding transaction.
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_out;
   logic          m_ready;
   logic          m_open;
   logic          m_open_wr;
   logic          m_prev_wr;
   int            m_age;

   pcm_mm_req_reg #(
      .ADDR_W(AW),
      .DATA_W(DW),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .init(init),
      .addr(addr),
      .cpu_write(cpu_write),
      .cpu_in(cpu_in),
      .data_in(data_in),
      .resolved(resolved),
      .schedule(schedule),
      .cpu_ready(cpu_ready),
      .cpu_out(cpu_out),
      .addr_reg(addr_reg)
   );

   always #5 clk = ~clk;

   function automatic logic m_new_req();
      logic wr_edge;
      wr_edge = cpu_write && !m_prev_wr;
      return !m_open && (wr_edge || addr != m_addr);
   endfunction

   task automatic model_reset();
      m_addr = '0; m_out = '0; m_ready = 0;
      m_open = 0; m_open_wr = 0; m_prev_wr = 0; m_age = 0;
   endtask

   // Apply one clock edge's worth of transaction rules to the model.
   task automatic model_edge();
      logic wr_edge, req;
      wr_edge = cpu_write && !m_prev_wr;
      req = m_new_req();
      if (init) begin
         m_addr = addr; m_open = 0; m_ready = 0;
      end else if (req) begin
         m_addr = addr; m_ready = 0; m_open = 1;
         m_open_wr = wr_edge; m_age = 0;
         if (wr_edge) m_out = cpu_in;
      end else if (m_open) begin
         if (resolved) begin
            if (!m_open_wr) m_out = data_in;
            m_ready = 1; m_open = 0;
         end else begin
`ifdef PCM_MM_REQ_TIMEOUT_EN
            m_age++;
            if (m_age == TMO) begin
               m_out = '1; m_ready = 1; m_open = 0;
            end
`endif
         end
      end
      m_prev_wr = cpu_write;
   endtask

   task automatic do_init(input logic [AW-1:0] a);
      @(negedge clk);
      init = 1; addr = a; cpu_write = 0; resolved = 0;
      @(posedge clk); #1;
      init = 0;
   endtask

   task automatic test_reset();
      reset = 1;
      #1;
      n_chk++;
      if (schedule !== 0 || cpu_ready !== 0 ||
          addr_reg !== 0 || cpu_out !== 0) begin
         n_fail++;
         $display("FAIL reset: sch=%b rdy=%b ar=%h out=%h want 0",
                  schedule, cpu_ready, addr_reg, cpu_out);
      end
      @(negedge clk); reset = 0;
      do_init(20'h00000);
      n_chk++;
      if (addr_reg !== 0 || schedule !== 0 || cpu_ready !== 0) begin
         n_fail++;
         $display("FAIL init: ar=%h sch=%b rdy=%b want 0/0/0",
                  addr_reg, schedule, cpu_ready);
      end
   endtask

   task automatic test_resolved_idle();
      @(negedge clk); resolved = 1;
      @(posedge clk); #1;
      @(negedge clk); resolved = 0;
      #1;
      n_chk++;
      if (cpu_ready !== 0 || schedule !== 0) begin
         n_fail++;
         $display("FAIL resolved_idle: rdy=%b sch=%b want 0/0",
                  cpu_ready, schedule);
      end
   endtask

   task automatic test_read();
      @(negedge clk); addr = 20'hFFFFF; #1;
      n_chk++;
      if (schedule !== 1) begin
         n_fail++;
         $display("FAIL read_sched0: sch=%b want 1", schedule);
      end
      @(posedge clk); #1;
      n_chk++;
      if (addr_reg !== 20'hFFFFF || schedule !== 1) begin
         n_fail++;
         $display("FAIL read_accept: ar=%h sch=%b want fffff/1",
                  addr_reg, schedule);
      end
      @(negedge clk); data_in = 16'h0FF0; resolved = 1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         n_chk++;
         if (cpu_ready !== 1 || cpu_out !== 16'h0FF0 ||
             schedule !== 0) begin
            n_fail++;
            $display("FAIL read_done%0d: rdy=%b out=%h sch=%b",
                     i, cpu_ready, cpu_out, schedule);
         end
      end
      @(negedge clk); resolved = 0;
   endtask

   task automatic test_write();
      @(negedge clk);
      cpu_in = 16'hABCD; addr = 20'h0ABCD; cpu_write = 1; #1;
      n_chk++;
      if (schedule !== 1) begin
         n_fail++;
         $display("FAIL write_sched0: sch=%b want 1", schedule);
      end
      @(posedge clk); #1;
      n_chk++;
      if (cpu_out !== 16'hABCD || schedule !== 1 || cpu_ready !== 0) begin
         n_fail++;
         $display("FAIL write_accept: out=%h sch=%b rdy=%b",
                  cpu_out, schedule, cpu_ready);
      end
      @(negedge clk); resolved = 1; data_in = 16'h1234;
      @(posedge clk); #1;
      n_chk++;
      if (cpu_ready !== 1 || cpu_out !== 16'hABCD) begin
         n_fail++;
         $display("FAIL write_done: rdy=%b out=%h want 1/abcd",
                  cpu_ready, cpu_out);
      end
      @(negedge clk); resolved = 0; cpu_in = 16'h5555;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_chk++;
         if (schedule !== 0 || cpu_ready !== 1 ||
             cpu_out !== 16'hABCD) begin
            n_fail++;
            $display("FAIL write_hold%0d: sch=%b rdy=%b out=%h",
                     i, schedule, cpu_ready, cpu_out);
         end
         @(negedge clk);
      end
      cpu_write = 0;
   endtask

   task automatic test_reset_mid();
      @(negedge clk); addr = 20'h12345;
      @(posedge clk); #3;
      reset = 1; #1;
      n_chk++;
      if (schedule !== 0 || cpu_ready !== 0 ||
          addr_reg !== 0 || cpu_out !== 0) begin
         n_fail++;
         $display("FAIL reset_mid: sch=%b rdy=%b ar=%h out=%h",
                  schedule, cpu_ready, addr_reg, cpu_out);
      end
      @(negedge clk); addr = '0; cpu_write = 0;
      @(negedge clk); reset = 0;
   endtask

`ifdef PCM_MM_REQ_TIMEOUT_EN
   task automatic test_timeout();
      do_init(20'h00000);
      @(negedge clk); addr = 20'h00055; resolved = 0;
      @(posedge clk); #1;
      for (int i = 1; i <= TMO; i++) begin
         @(posedge clk); #1;
         n_chk++;
         if (i < TMO && cpu_ready !== 0) begin
            n_fail++;
            $display("FAIL tmo_early%0d: rdy=%b want 0", i, cpu_ready);
         end else if (i == TMO &&
                      (cpu_ready !== 1 || cpu_out !== 16'hFFFF)) begin
            n_fail++;
            $display("FAIL tmo_fire: rdy=%b out=%h want 1/ffff",
                     cpu_ready, cpu_out);
         end
      end
   endtask
`endif

   task automatic test_random();
      logic exp_sch;
      do_init(20'h00000);
      model_reset();
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         init      = ($urandom_range(0, 29) == 0);
         cpu_write = ($urandom_range(0, 3) == 0) ? ~cpu_write : cpu_write;
         if ($urandom_range(0, 4) == 0)
            addr = AW'($urandom_range(0, 7) << 13);
         cpu_in    = DW'($urandom);
         data_in   = DW'($urandom);
         resolved  = ($urandom_range(0, 5) == 0);
         #1;
         exp_sch = !init && (m_open || m_new_req());
         n_chk++;
         if (schedule !== exp_sch) begin
            n_fail++;
            $display("FAIL rnd_sched c=%0d: got %b want %b",
                     c, schedule, exp_sch);
         end
         @(posedge clk);
         model_edge();
         #1;
         n_chk++;
         if (addr_reg !== m_addr || cpu_out !== m_out ||
             cpu_ready !== m_ready) begin
            n_fail++;
            $display("FAIL rnd_regs c=%0d: ar=%h/%h out=%h/%h rdy=%b/%b",
                     c, addr_reg, m_addr, cpu_out, m_out,
                     cpu_ready, m_ready);
         end
      end
      @(negedge clk);
      init = 0; resolved = 0; cpu_write = 0;
   endtask

   initial begin
      test_reset();
      test_resolved_idle();
      test_read();
      test_write();
      test_reset_mid();
      do_init(20'h00000);
`ifdef PCM_MM_REQ_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pcm_mm_req_reg.md
Name: pcm_mm_req_reg

Overview:
Per-CPU request register for the PCM memory manager.
- Holds one CPU's outstanding memory request: address, and write data or returned read data.
- Raises `schedule` to the shared PCM arbiter.
- Completes the request when the arbiter pulses `resolved`, then presents `cpu_ready` and `cpu_out` to the CPU.
- One instance per CPU port (cpu0..cpu3) inside the PCM memory-manager top.

Parameters:
- ADDR_W, 20, address width
- DATA_W, 16, data width
- TIMEOUT_CYCLES, 64, pending-cycle limit (optional feature only)

Ports:
- clk  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- init  in  1  synchronous re-initialise; loads addr_reg from addr
- addr  in  ADDR_W  CPU request address
- cpu_write  in  1  CPU write request, level
- cpu_in  in  DATA_W  CPU write data
- data_in  in  DATA_W  read data returned from PCM memory
- resolved  in  1  arbiter: current request serviced
- schedule  out  1  request pending, to arbiter
- cpu_ready  out  1  request complete
- cpu_out  out  DATA_W  data register: write data toward memory, or read data toward CPU
- addr_reg  out  ADDR_W  latched request address

Behaviour:
- States: IDLE, PENDING, DONE. The state, addr_reg, cpu_out, cpu_ready and the previous-cpu_write flop are registers.
- Reset (async, any time, including mid-request):
  - state=IDLE
  - addr_reg=0, cpu_out=0, cpu_ready=0, schedule=0
  - previous-cpu_write flop=0
- init (sync, highest priority over all other inputs):
  - addr_reg<=addr, state<=IDLE, cpu_ready<=0
  - cpu_out unchanged
- New request in IDLE or DONE is defined as:
  - a read: addr != addr_reg, or
  - a write: rising edge of cpu_write (cpu_write=1 and prev=0).
  - Write takes precedence if both occur.
- On the edge that accepts a new request:
  - addr_reg<=addr
  - for a write, cpu_out<=cpu_in
  - cpu_ready<=0
  - state<=PENDING
- schedule is combinational:
  - 1 while state==PENDING;
  - also 1 in IDLE/DONE in the same cycle a new request is detected, so the arbiter sees it with zero latency;
  - 0 during init and reset.
- PENDING:
  - addr and cpu_write changes are ignored.
  - On resolved=1: read requests load cpu_out<=data_in; write requests leave cpu_out unchanged.
  - On resolved=1: cpu_ready<=1, state<=DONE.
  - Latency: cpu_ready is high one clock after the resolved edge.
- DONE:
  - cpu_ready and cpu_out hold until a new request or init.
  - A new request drops cpu_ready on the accepting edge.
- resolved outside PENDING: ignored.
- resolved in the same cycle as a new-request detect in IDLE/DONE: request is accepted, resolved is ignored.
- Addresses compare on the full ADDR_W width; there is no wrap logic.

Optional Feature:
- Macro: PCM_MM_REQ_TIMEOUT_EN.
- Defined:
  - a counter runs in PENDING and clears on entry to PENDING;
  - if TIMEOUT_CYCLES elapse without resolved, the request completes with cpu_out<=all-ones, cpu_ready<=1, state<=DONE;
  - resolved on the same cycle as expiry wins (normal completion).
- Undefined: no counter; PENDING waits indefinitely.

Decomposition:
- Package pcm_mm_pkg holds:
  - ADDR_W and DATA_W defaults
  - state enum req_state_t {IDLE, PENDING, DONE}
  - the timeout fill constant (all-ones)
- No sub-module; the block is a single FSM plus registers.
- The PCM_MM top instantiates four copies.

Test Plan:
- Reset release, then init with addr=20'h00000 -> addr_reg=0, schedule=0, cpu_ready=0.
- After init, resolved pulse in IDLE -> no state change; cpu_ready stays 0.
- Read request:
  - addr=20'hFFFFF -> schedule=1 in the same cycle; next edge addr_reg=20'hFFFFF, schedule stays 1.
  - data_in=16'h0FF0, resolved=1 -> one clock later cpu_ready=1, cpu_out=16'h0FF0, schedule=0; values hold while resolved stays high.
- Write request:
  - cpu_in=16'hABCD, addr=20'h0ABCD, cpu_write 0->1 -> cpu_out=16'hABCD, schedule=1.
  - resolved -> cpu_ready=1, cpu_out still 16'hABCD.
  - cpu_write held high afterwards -> no second request.
- Reset mid-request: assert reset during PENDING -> immediately schedule=0, cpu_ready=0, addr_reg=0, cpu_out=0.
- With PCM_MM_REQ_TIMEOUT_EN and TIMEOUT_CYCLES=4: read request with no resolved -> after 4 cycles cpu_ready=1, cpu_out=16'hFFFF.
